// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed 8N1 UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter; bit_end flags the last clock of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic ck,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count_q, count_d;

    assign bit_end = (count_q == LAST);

    always_comb begin
        count_d = count_q + W'(1);
        if (clear || bit_end) count_d = '0;
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a show-ahead FIFO and sends each as an 8N1 frame, LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  ck,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  remove,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0]            idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;
    logic                  timer_clear;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .ck      (ck),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        remove  = 1'b0;
        tx_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so no pop strobe leaks out while the block is held.
                remove = enable & ~empty & ~reset;
                if (remove) begin
                    shift_d = fifo_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                tx_done = bit_end;
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        timer_clear = (state_d != state_q);

        // Line level follows the next state so tx drops on the popping edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a queue standing in for the FIFO.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       remove, tx, busy, tx_done;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .ck        (ck),
        .reset     (reset),
        .enable    (enable),
        .empty     (empty),
        .fifo_data (fifo_data),
        .remove    (remove),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 is sent first: start, d0..d7, stop
    } vec_t;

    logic [7:0] q[$];
    logic       pend = 1'b0;
    logic       en_req = 1'b0;
    logic       rst_req = 1'b1;
    logic       s_tx, s_rem, s_busy, s_done;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // One clock: update FIFO model and inputs at the falling edge, then sample outputs.
    task automatic step();
        @(negedge ck);
        if (pend && q.size() > 0) void'(q.pop_front());
        pend      = 1'b0;
        empty     = (q.size() == 0);
        fifo_data = empty ? 8'h00 : q[0];
        enable    = en_req;
        reset     = rst_req;
        #1;
        s_tx   = tx;
        s_rem  = remove;
        s_busy = busy;
        s_done = tx_done;
        pend   = remove;
    endtask

    // Waits for a pop, then checks the whole 40-cycle frame; returns cycles waited.
    task automatic check_frame(input logic [9:0] exp, input string nm, input int drop_at,
                               output int waited);
        logic ok, done_bad, rem_bad, busy_bad;
        int   cnt;
        waited = 0;
        while (!s_rem && waited < 200) begin
            step();
            waited++;
        end
        chk({nm, "_pop"}, 32'(s_rem), 32'd1);
        if (s_rem) begin
            done_bad = 1'b0;
            rem_bad  = 1'b0;
            busy_bad = 1'b0;
            for (int b = 0; b < 10; b++) begin
                ok = 1'b1;
                for (int k = 0; k < CPB; k++) begin
                    step();
                    cnt = b * CPB + k + 1;
                    if (cnt == drop_at) en_req = 1'b0;
                    if (s_tx !== exp[b]) ok = 1'b0;
                    if (s_done !== (cnt == 10 * CPB)) done_bad = 1'b1;
                    if (s_rem !== 1'b0) rem_bad = 1'b1;
                    if (s_busy !== 1'b1) busy_bad = 1'b1;
                end
                chk($sformatf("%s_bit%0d", nm, b), 32'(ok), 32'd1);
            end
            chk({nm, "_tx_done"}, 32'(done_bad), 32'd0);
            chk({nm, "_no_pop"}, 32'(rem_bad), 32'd0);
            chk({nm, "_busy"}, 32'(busy_bad), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   w;
        logic bad_rem, bad_tx, bad_busy;

        vecs[0] = '{data: 8'h01, frame: 10'h202};
        vecs[1] = '{data: 8'h55, frame: 10'h2AA};
        vecs[2] = '{data: 8'h80, frame: 10'h300};
        vecs[3] = '{data: 8'hFF, frame: 10'h3FE};

        // Reset held with data available and enable high: nothing may move.
        q.push_back(8'hEE);
        en_req = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_tx", 32'(s_tx), 32'd1);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_remove", 32'(s_rem), 32'd0);
        chk("rst_tx_done", 32'(s_done), 32'd0);
        q.delete();
        rst_req = 1'b0;
        step();
        step();
        chk("idle_tx", 32'(s_tx), 32'd1);

        // Single-byte frames from the table.
        for (int i = 0; i < 4; i++) begin
            q.push_back(vecs[i].data);
            check_frame(vecs[i].frame, $sformatf("vec%0d", i), 0, w);
            step();
            chk($sformatf("vec%0d_idle_busy", i), 32'(s_busy), 32'd0);
            chk($sformatf("vec%0d_idle_tx", i), 32'(s_tx), 32'd1);
        end

        // Back-to-back: second pop lands 41 cycles after the first.
        for (int i = 0; i < 5; i++) step();
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        check_frame(10'h34A, "b2b_a5", 0, w);
        check_frame(10'h278, "b2b_3c", 0, w);
        chk("b2b_gap", 32'(w), 32'd1);
        bad_tx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_tx !== 1'b1 || s_rem !== 1'b0) bad_tx = 1'b1;
        end
        chk("b2b_empty", 32'(empty), 32'd1);
        chk("b2b_tail_idle", 32'(bad_tx), 32'd0);

        // Empty FIFO with enable high.
        bad_rem = 1'b0;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (s_rem !== 1'b0) bad_rem = 1'b1;
            if (s_tx !== 1'b1) bad_tx = 1'b1;
            if (s_busy !== 1'b0) bad_busy = 1'b1;
        end
        chk("empty_remove", 32'(bad_rem), 32'd0);
        chk("empty_tx", 32'(bad_tx), 32'd0);
        chk("empty_busy", 32'(bad_busy), 32'd0);

        // Enable dropped mid-frame: frame finishes, next byte stays queued.
        q.push_back(8'hFF);
        q.push_back(8'h01);
        check_frame(10'h3FE, "drop", 10, w);
        bad_rem = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (s_rem !== 1'b0) bad_rem = 1'b1;
            if (s_busy !== 1'b0) bad_busy = 1'b1;
        end
        chk("drop_no_pop", 32'(bad_rem), 32'd0);
        chk("drop_busy", 32'(bad_busy), 32'd0);
        chk("drop_left", 32'(q.size()), 32'd1);
        q.delete();
        step();

        // Reset in cycle 15 of a 0x55 frame, then a clean frame for 0x3C.
        q.push_back(8'h55);
        q.push_back(8'h3C);
        en_req = 1'b1;
        w = 0;
        while (!s_rem && w < 200) begin
            step();
            w++;
        end
        chk("mid_pop", 32'(s_rem), 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("mid_busy_before", 32'(s_busy), 32'd1);
        #1;
        reset = 1'b1;
        rst_req = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_remove", 32'(remove), 32'd0);
        chk("mid_rst_tx_done", 32'(tx_done), 32'd0);
        step();
        step();
        chk("mid_rst_hold_remove", 32'(s_rem), 32'd0);
        rst_req = 1'b0;
        check_frame(10'h278, "after_rst", 0, w);
        chk("after_rst_wait", 32'(w), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Consumer end of the byte FIFO: pops bytes from the FIFO read port and serialises each as an 8N1 asynchronous frame (start bit, 8 data bits LSB first, stop bit) on a single line. It is instantiated next to the FIFO, driving its `remove` input and taking its `empty` and `data_out` outputs. This gives the buffered byte stream a physical transmit path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `DATA_WIDTH`, default 8: byte width; fixed at 8 for 8N1. It is present for width checks only.

Ports:
- `ck`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits starting a new frame; sampled only in IDLE.
- `empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO `data_out`, the head byte. It is valid whenever `empty`=0 (show-ahead read).
- `remove`  out  1  FIFO pop strobe, one cycle per byte.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `remove = enable & ~empty`. This is combinational from the state register and the inputs.
  - On an edge with `remove`=1:
    - the shift register loads `fifo_data`;
    - the bit timer clears;
    - the state moves to START.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then the state moves to DATA with bit index 0.
- **DATA**
  - `tx` = shift register bit 0 for `CLKS_PER_BIT` cycles.
  - The register then shifts right and the index increments.
  - After index 7 completes, the state moves to STOP.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `tx_done`=1 in the final cycle.
  - The state then moves to IDLE.
- Bit timer
  - Width is `$clog2(CLKS_PER_BIT)`; it counts 0..`CLKS_PER_BIT`-1.
  - Terminal count produces `bit_end`.
  - The timer is cleared on every state change.
- Bit index is 3 bits; it wraps from 7 to 0 at exit from DATA.
- `tx` is registered. It is driven from the FSM and shift register, never from `fifo_data` directly.

## Timing
- Reset values:
  - state IDLE, `tx`=1, `busy`=0, `tx_done`=0, `remove`=0;
  - shift register 0x00, timer 0, bit index 0.
- Latency:
  - `tx` falls on the edge that samples `remove`=1.
  - A frame lasts exactly `10*CLKS_PER_BIT` cycles.
- Back-to-back frames:
  - STOP always returns to IDLE for exactly one cycle.
  - During that cycle `remove` may reassert, giving a frame period of `10*CLKS_PER_BIT+1` cycles.
- `enable` deasserted mid-frame: the current frame completes normally, and no further pop occurs.
- `empty`=1 in IDLE: `remove`=0 and `tx` stays high indefinitely.
- `empty` is ignored outside IDLE. A FIFO flush mid-frame does not abort the frame.
- Reset mid-frame:
  - all outputs return immediately (asynchronously) to their reset values;
  - the partially sent byte is lost, because it was already popped.
- `remove` is never asserted for two consecutive cycles.

## Structure
- A shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `FRAME_BITS`=10;
  - a `DATA_WIDTH` localparam of 8.
- One sub-module, `bit_timer`:
  - parameter `CLKS_PER_BIT`;
  - inputs `ck`, `reset`, `clear`;
  - output `bit_end`.
- The top module holds the FSM, shift register and bit index.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Reset:** assert `reset` mid-cycle with `empty`=0 → `tx`=1, `busy`=0 and `remove`=0 immediately, held while `reset`=1.
- **Single byte:** FIFO holds 0x01, `enable`=1 →
  - `remove` pulses once;
  - `tx` is 0 for 4 cycles, then 1 for 4 cycles, then 0 for 28 cycles, then 1 for 4 cycles;
  - `tx_done` pulses in cycle 40.
- **Back-to-back:** FIFO holds 0xA5 then 0x3C →
  - two `remove` pulses 41 cycles apart;
  - the line decodes LSB-first as 0xA5 then 0x3C;
  - `empty` ends at 1 and `tx` stays high.
- **Empty:** `empty`=1 and `enable`=1 for 100 cycles → `remove`=0, `tx`=1, `busy`=0 throughout.
- **Enable drop:** deassert `enable` 10 cycles into a 0xFF frame, with the FIFO still non-empty →
  - the frame completes (40 cycles);
  - no further `remove`;
  - `busy`=0 afterwards.
- **Reset mid-frame:** assert `reset` in cycle 15 of a 0x55 frame → `tx`=1 at once. After release with `empty`=0, the next byte starts a clean frame.
